bus_mem_mmio: RTL and testbench
===============================

# bus_mem_mmio

Parametrised, synthesizable memory-and-MMIO slave for the 16-bit CPU data bus, replacing the behavioural memory model in CPU test setups and FPGA bring-up. It provides a word-addressed RAM with configurable read latency and periodic wait-state injection, plus two MMIO endpoints: a result register and a hardware string-print engine. The string engine walks a null-terminated string in RAM and streams its characters out on a valid/ready byte port. It sits directly on the CPU's `mem` bus.

## Interface
- `ADDR_W`, 16, byte address width.
- `DATA_W`, 16, bus word width; characters are `[7:0]` of each word.
- `DEPTH_LOG2`, 15, log2 of RAM words; the RAM is indexed by `i_mem_addr[DEPTH_LOG2:1]`.
- `RD_LATENCY`, 1, legal range 1..4; cycles from request acceptance to `o_mem_rddatavalid`.
- `WAIT_PERIOD`, 0. When 0, the block never injects waits. When N > 0, the block stalls for 1 cycle after every N accepted requests.
- `RESULT_ADDR`, 16'h1000, byte address of the result register.
- `STRING_ADDR`, 16'h1002, byte address of the string-print trigger.
- `MAX_STR`, 512, maximum number of characters before the engine reports an error.
- `INIT_FILE`, "", hex file loaded into RAM with `$readmemh`; empty means no initialisation.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `i_mem_addr`, in, ADDR_W: byte address of the request.
- `i_mem_rd`, in, 1: read request.
- `i_mem_wr`, in, 1: write request.
- `i_mem_wrdata`, in, DATA_W: write data.
- `o_mem_rddata`, out, DATA_W: read data; 0 whenever `o_mem_rddatavalid` is 0.
- `o_mem_wait`, out, 1: stall; requests are not accepted while it is 1.
- `o_mem_rddatavalid`, out, 1: one-cycle pulse marking valid read data.
- `o_result`, out, DATA_W: last value written to RESULT_ADDR.
- `o_result_valid`, out, 1: one-cycle pulse when the result register is written.
- `o_char`, out, 8: current character.
- `o_char_valid`, out, 1: character valid.
- `i_char_ready`, in, 1: character consumer ready.
- `o_str_done`, out, 1: one-cycle pulse when the null terminator is reached.
- `o_str_err`, out, 1: one-cycle pulse when MAX_STR characters are emitted without a terminator.

## Operation
- A request is accepted in a cycle where `(i_mem_rd | i_mem_wr) & ~o_mem_wait`.
- Writes update RAM at the edge ending the acceptance cycle.
- Reads and writes at the same word in the same cycle are read-before-write: the read returns the old word.
- Reads to MMIO addresses return the RAM word at that address.
- Writes to MMIO addresses also update RAM.
- Address aliasing: bits above DEPTH_LOG2 and bit 0 are ignored.
- Result register: an accepted write to RESULT_ADDR loads `o_result` and pulses `o_result_valid`.
- String engine: an accepted write to STRING_ADDR loads the pointer with `{i_mem_wrdata[ADDR_W-1:1],1'b0}` and starts the FSM.
- FSM states:
  - IDLE: on trigger, go to FETCH.
  - FETCH: issue an internal read at the pointer; the data is available next cycle. Go to CHECK.
  - CHECK: if the word == 0, pulse `o_str_done` and go to IDLE. Else, if the count == MAX_STR, pulse `o_str_err` and go to IDLE. Else go to EMIT.
  - EMIT: hold `o_char_valid` and `o_char`. On `i_char_ready`, pointer += 2 (wraps modulo 2^ADDR_W), count += 1, go to FETCH.
- Null words are never emitted.
- `o_mem_wait` = 1 whenever the FSM is not IDLE; the engine owns the RAM port.
- A write to STRING_ADDR while the engine is busy cannot occur, because the bus is stalled.
- Wait injection: an accepted-request counter counts up to WAIT_PERIOD. The cycle after the Nth acceptance, `o_mem_wait` = 1 and the counter clears. Requests held during wait are accepted the following cycle.
- Reads accepted back-to-back pipeline fully: one result per cycle, in order.

## Timing
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - pointer, count and wait counter 0;
  - latency pipeline valid bits cleared, so in-flight reads are dropped.
- RAM contents are not reset.
- Read accepted at cycle t → `o_mem_rddatavalid` = 1 at cycle t+RD_LATENCY.
- `o_result_valid` asserts the cycle after the write is accepted.
- String engine: trigger accepted at t → FETCH at t+1 → CHECK at t+2 → first `o_char_valid` at t+3 (with `i_char_ready` held at 1).
- With `i_char_ready` held at 1, the engine spends 3 cycles per character.
- `o_mem_wait` rises at t+1 and falls in the cycle the FSM returns to IDLE.
- Reset asserted mid-string: FSM returns to IDLE, `o_char_valid` drops next edge, no done/err pulse.

## Test plan
- RD_LATENCY=3, WAIT_PERIOD=0: write 16'hBEEF to 0x0040, read 0x0040 the next cycle → `o_mem_rddata`=16'hBEEF with `o_mem_rddatavalid` exactly 3 cycles after acceptance. Back-to-back reads of 0x0040/0x0042 → two consecutive valid pulses, in order.
- WAIT_PERIOD=2: hold reads continuously for 6 cycles → `o_mem_wait` high on cycles 3 and 6. Only 4 acceptances occur and no request is lost.
- Write 16'h000F to 0x1000 → `o_result`=16'h000F, one-cycle `o_result_valid`. RAM word 0x800 reads back 16'h000F.
- Preload "Hi" (16'h0048, 16'h0069, 16'h0000) at 0x0100; write 16'h0101 to 0x1002 with `i_char_ready` toggling → chars 'H','i' emitted in order, each held until ready. `o_str_done` fires once; bus is stalled throughout.
- MAX_STR=4 with no terminator in memory → 4 chars emitted, then `o_str_err` pulse and no done pulse. A string placed at 0xFFFE wraps to 0x0000.
- Assert `reset` during EMIT → the next cycle `o_char_valid`=0, `o_mem_wait`=0 and the FSM is IDLE. A subsequent trigger restarts the engine cleanly.

Source files
------------

// File: rtl/bus_mem_mmio.sv
// Word RAM slave for the 16-bit CPU data bus with pipelined reads and periodic wait
// injection, plus a result register and an engine that streams a null-terminated string.
//
// state | meaning
// IDLE  | engine free, bus requests serviced
// FETCH | internal RAM read at the string pointer
// CHECK | fetched word tested for terminator, then for length limit
// EMIT  | character presented until the consumer is ready
module bus_mem_mmio #(
   parameter int                ADDR_W      = 16,
   parameter int                DATA_W      = 16,
   parameter int                DEPTH_LOG2  = 15,
   parameter int                RD_LATENCY  = 1,
   parameter int                WAIT_PERIOD = 0,
   parameter logic [ADDR_W-1:0] RESULT_ADDR = 16'h1000,
   parameter logic [ADDR_W-1:0] STRING_ADDR = 16'h1002,
   parameter int                MAX_STR     = 512,
   parameter string             INIT_FILE   = ""
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic              i_mem_rd,
   input  logic              i_mem_wr,
   input  logic [DATA_W-1:0] i_mem_wrdata,
   output logic [DATA_W-1:0] o_mem_rddata,
   output logic              o_mem_wait,
   output logic              o_mem_rddatavalid,
   output logic [DATA_W-1:0] o_result,
   output logic              o_result_valid,
   output logic [7:0]        o_char,
   output logic              o_char_valid,
   input  logic              i_char_ready,
   output logic              o_str_done,
   output logic              o_str_err
);

   localparam int CNT_W = $clog2(MAX_STR + 1);
   localparam int WC_W  = (WAIT_PERIOD > 1) ? $clog2(WAIT_PERIOD) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, CHECK, EMIT} state_t;
   state_t state, state_nxt;

   logic [DATA_W-1:0]                  mem [2**DEPTH_LOG2];
   logic [RD_LATENCY-1:0][DATA_W-1:0] pipe_d;
   logic [RD_LATENCY-1:0]             pipe_v;
   logic [ADDR_W-1:0]                 ptr;
   logic [CNT_W-1:0]                  cnt;
   logic [7:0]                        char_q;
   logic [DEPTH_LOG2-1:0]             rd_idx;
   logic wait_inj, accept, wr_acc, rd_acc, hit_result, hit_string, trigger;
   logic word_zero, at_limit;
   logic unused_ok;

   assign o_mem_wait = (state != IDLE) | wait_inj;
   assign accept     = (i_mem_rd | i_mem_wr) & ~o_mem_wait;
   assign wr_acc     = accept & i_mem_wr;
   assign rd_acc     = accept & i_mem_rd;
   assign hit_result = i_mem_addr[ADDR_W-1:1] == RESULT_ADDR[ADDR_W-1:1];
   assign hit_string = i_mem_addr[ADDR_W-1:1] == STRING_ADDR[ADDR_W-1:1];
   assign trigger    = wr_acc & hit_string;
   assign word_zero  = pipe_d[0] == '0;
   assign at_limit   = cnt == CNT_W'(MAX_STR);
   assign unused_ok  = i_mem_addr[0];

   // The engine borrows the single read port in FETCH; the bus is stalled then.
   assign rd_idx = (state == FETCH) ? ptr[DEPTH_LOG2:1] : i_mem_addr[DEPTH_LOG2:1];

   assign o_mem_rddatavalid = pipe_v[RD_LATENCY-1];
   assign o_mem_rddata      = pipe_v[RD_LATENCY-1] ? pipe_d[RD_LATENCY-1] : '0;
   assign o_char            = char_q;

   // Read happens on the same edge as the write, so it returns the old word.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[i_mem_addr[DEPTH_LOG2:1]] <= i_mem_wrdata;
      pipe_d[0] <= mem[rd_idx];
      for (int k = 1; k < RD_LATENCY; k++) pipe_d[k] <= pipe_d[k-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_v         <= '0;
         o_result       <= '0;
         o_result_valid <= 1'b0;
      end else begin
         pipe_v[0] <= rd_acc;
         for (int k = 1; k < RD_LATENCY; k++) pipe_v[k] <= pipe_v[k-1];
         o_result_valid <= wr_acc & hit_result;
         if (wr_acc & hit_result) o_result <= i_mem_wrdata;
      end
   end

   generate
      if (WAIT_PERIOD > 0) begin : g_wait
         logic [WC_W-1:0] acc_cnt;
         always_ff @(posedge clk) begin
            if (reset) begin
               acc_cnt  <= '0;
               wait_inj <= 1'b0;
            end else begin
               wait_inj <= 1'b0;
               if (accept) begin
                  if (acc_cnt == WC_W'(WAIT_PERIOD - 1)) begin
                     acc_cnt  <= '0;
                     wait_inj <= 1'b1;
                  end else begin
                     acc_cnt <= acc_cnt + 1'b1;
                  end
               end
            end
         end
      end else begin : g_no_wait
         assign wait_inj = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      o_char_valid = 1'b0;
      o_str_done   = 1'b0;
      o_str_err    = 1'b0;
      case (state)
         IDLE:  if (trigger) state_nxt = FETCH;
         FETCH: state_nxt = CHECK;
         CHECK: begin
            if (word_zero) begin
               o_str_done = 1'b1;
               state_nxt  = IDLE;
            end else if (at_limit) begin
               o_str_err = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            o_char_valid = 1'b1;
            if (i_char_ready) state_nxt = FETCH;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr    <= '0;
         cnt    <= '0;
         char_q <= '0;
      end else begin
         if (state == IDLE && trigger) begin
            ptr <= {i_mem_wrdata[ADDR_W-1:1], 1'b0};
            cnt <= '0;
         end
         if (state == CHECK) char_q <= pipe_d[0][7:0];
         if (state == EMIT && i_char_ready) begin
            ptr <= ptr + ADDR_W'(2);
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bus_mem_mmio.sv
// Directed bench for bus_mem_mmio: dut_a (latency 3, no waits, MAX_STR 4) and
// dut_b (latency 1, wait every 2 acceptances, 256-word RAM for aliasing).
module tb_bus_mem_mmio;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic [15:0] a_addr, a_wrdata, a_rddata, a_result;
   logic        a_rd, a_wr, a_wait, a_rdv, a_resv, a_charv, a_ready, a_done, a_err;
   logic [7:0]  a_char;
   logic [15:0] b_addr, b_wrdata, b_rddata, b_result;
   logic        b_rd, b_wr, b_wait, b_rdv, b_resv, b_charv, b_ready, b_done, b_err;
   logic [7:0]  b_char;

   int vec_cnt = 0;
   int miss_cnt = 0;

   bus_mem_mmio #(.RD_LATENCY(3), .WAIT_PERIOD(0), .MAX_STR(4)) dut_a (
      .clk(clk), .reset(reset), .i_mem_addr(a_addr), .i_mem_rd(a_rd), .i_mem_wr(a_wr),
      .i_mem_wrdata(a_wrdata), .o_mem_rddata(a_rddata), .o_mem_wait(a_wait),
      .o_mem_rddatavalid(a_rdv), .o_result(a_result), .o_result_valid(a_resv),
      .o_char(a_char), .o_char_valid(a_charv), .i_char_ready(a_ready),
      .o_str_done(a_done), .o_str_err(a_err));

   bus_mem_mmio #(.DEPTH_LOG2(8), .RD_LATENCY(1), .WAIT_PERIOD(2)) dut_b (
      .clk(clk), .reset(reset), .i_mem_addr(b_addr), .i_mem_rd(b_rd), .i_mem_wr(b_wr),
      .i_mem_wrdata(b_wrdata), .o_mem_rddata(b_rddata), .o_mem_wait(b_wait),
      .o_mem_rddatavalid(b_rdv), .o_result(b_result), .o_result_valid(b_resv),
      .o_char(b_char), .o_char_valid(b_charv), .i_char_ready(b_ready),
      .o_str_done(b_done), .o_str_err(b_err));

   task automatic a_write(input logic [15:0] addr, input logic [15:0] data);
      @(negedge clk); a_addr = addr; a_wr = 1'b1; a_wrdata = data;
      @(negedge clk); a_wr = 1'b0;
   endtask

   // Issues one read on dut_a and returns the data seen 3 cycles later.
   task automatic a_read(input logic [15:0] addr, output logic [15:0] data, output logic timing_ok);
      @(negedge clk); a_addr = addr; a_rd = 1'b1;
      timing_ok = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk); a_rd = 1'b0; #1;
         if (a_rdv !== 1'(k == 3)) timing_ok = 1'b0;
      end
      data = a_rddata;
   endtask

   // Holds a dut_b request until accepted; returns in the cycle after acceptance.
   task automatic b_req(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] data);
      int n;
      @(negedge clk); b_rd = rd; b_wr = wr; b_addr = addr; b_wrdata = data; #1;
      n = 0;
      while (b_wait !== 1'b0 && n < 8) begin @(negedge clk); #1; n++; end
      if (n >= 8) begin miss_cnt++; $display("FAIL b_accept_timeout addr %h", addr); end
      @(negedge clk); b_rd = 1'b0; b_wr = 1'b0; #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      vec_cnt++;
      if ({a_rdv, a_wait, a_resv, a_charv, a_done, a_err} !== 6'b0)
         begin miss_cnt++; $display("FAIL reset_a_flags got %b want 000000", {a_rdv, a_wait, a_resv, a_charv, a_done, a_err}); end
      vec_cnt++;
      if ({a_rddata, a_result, a_char} !== 40'h0)
         begin miss_cnt++; $display("FAIL reset_a_data got %h want 0", {a_rddata, a_result, a_char}); end
      vec_cnt++;
      if ({b_rdv, b_wait, b_resv, b_charv, b_done, b_err} !== 6'b0)
         begin miss_cnt++; $display("FAIL reset_b_flags got %b want 000000", {b_rdv, b_wait, b_resv, b_charv, b_done, b_err}); end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_read_latency();
      a_write(16'h0040, 16'hBEEF);
      a_addr = 16'h0040; a_rd = 1'b1; #1;
      vec_cnt++;
      if (a_wait !== 1'b0) begin miss_cnt++; $display("FAIL lat_accept wait got %b want 0", a_wait); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); a_rd = 1'b0; #1;
         vec_cnt++;
         if (a_rdv !== 1'(k == 3) || a_rddata !== ((k == 3) ? 16'hBEEF : 16'h0000))
            begin miss_cnt++; $display("FAIL lat3_read offset %0d got v=%b d=%h want v=%b", k, a_rdv, a_rddata, k == 3); end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] d, exp_d;
      logic ok, exp_v;
      a_write(16'h0042, 16'h1234);
      a_addr = 16'h0040; a_rd = 1'b1;
      @(negedge clk); a_addr = 16'h0042;
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk); a_rd = 1'b0; #1;
         exp_v = (k == 3 || k == 4);
         exp_d = (k == 3) ? 16'hBEEF : (k == 4) ? 16'h1234 : 16'h0000;
         vec_cnt++;
         if (a_rdv !== exp_v || a_rddata !== exp_d)
            begin miss_cnt++; $display("FAIL b2b offset %0d got v=%b d=%h want v=%b d=%h", k, a_rdv, a_rddata, exp_v, exp_d); end
      end
      // Same-word read and write in one cycle: read sees the old word.
      a_addr = 16'h0040; a_rd = 1'b1; a_wr = 1'b1; a_wrdata = 16'h5555;
      for (int k = 1; k <= 3; k++) begin @(negedge clk); a_rd = 1'b0; a_wr = 1'b0; end
      #1;
      vec_cnt++;
      if (a_rdv !== 1'b1 || a_rddata !== 16'hBEEF)
         begin miss_cnt++; $display("FAIL rbw_old got v=%b d=%h want v=1 d=beef", a_rdv, a_rddata); end
      a_read(16'h0040, d, ok);
      vec_cnt++;
      if (d !== 16'h5555 || ok !== 1'b1)
         begin miss_cnt++; $display("FAIL rbw_new got d=%h timing=%b want 5555 1", d, ok); end
   endtask

   task automatic test_result();
      logic [15:0] d;
      logic ok;
      a_write(16'h1000, 16'h000F); #1;
      vec_cnt++;
      if (a_resv !== 1'b1 || a_result !== 16'h000F)
         begin miss_cnt++; $display("FAIL result_pulse got v=%b r=%h want 1 000f", a_resv, a_result); end
      @(negedge clk); #1;
      vec_cnt++;
      if (a_resv !== 1'b0 || a_result !== 16'h000F)
         begin miss_cnt++; $display("FAIL result_hold got v=%b r=%h want 0 000f", a_resv, a_result); end
      a_read(16'h1000, d, ok);
      vec_cnt++;
      if (d !== 16'h000F || ok !== 1'b1)
         begin miss_cnt++; $display("FAIL result_ram got d=%h timing=%b want 000f 1", d, ok); end
      a_read(16'h1001, d, ok);
      vec_cnt++;
      if (d !== 16'h000F) begin miss_cnt++; $display("FAIL result_alias_bit0 got %h want 000f", d); end
   endtask

   task automatic test_aliasing();
      b_req(1'b0, 1'b1, 16'h0010, 16'hA5A5);
      b_req(1'b1, 1'b0, 16'h0211, 16'h0000);
      vec_cnt++;
      if (b_rdv !== 1'b1 || b_rddata !== 16'hA5A5)
         begin miss_cnt++; $display("FAIL alias_read got v=%b d=%h want 1 a5a5", b_rdv, b_rddata); end
   endtask

   task automatic test_wait_inject();
      int acc, got;
      logic exp_w;
      for (int i = 0; i < 4; i++) b_req(1'b0, 1'b1, 16'h0020 + 16'(2 * i), 16'hC000 + 16'(i));
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      acc = 0; got = 0;
      for (int c = 1; c <= 7; c++) begin
         if (c > 1) @(negedge clk);
         b_rd = (c <= 6); b_addr = 16'h0020 + 16'(2 * acc); #1;
         if (b_rdv === 1'b1) begin
            vec_cnt++;
            if (b_rddata !== 16'hC000 + 16'(got))
               begin miss_cnt++; $display("FAIL wait_data #%0d got %h want %h", got, b_rddata, 16'hC000 + 16'(got)); end
            got++;
         end
         if (c <= 6) begin
            exp_w = (c == 3 || c == 6);
            vec_cnt++;
            if (b_wait !== exp_w) begin miss_cnt++; $display("FAIL wait_cycle %0d got %b want %b", c, b_wait, exp_w); end
            if (b_wait === 1'b0) acc++;
         end
      end
      b_rd = 1'b0;
      vec_cnt++;
      if (acc != 4 || got != 4) begin miss_cnt++; $display("FAIL wait_counts got acc=%0d rd=%0d want 4 4", acc, got); end
   endtask

   task automatic test_string();
      logic [7:0] chars [4];
      logic [7:0] held;
      logic busy_ok, hold_ok, stalled;
      int nchar, ndone, nerr, done_c, idle_c;
      a_write(16'h0100, 16'h0048);
      a_write(16'h0102, 16'h0069);
      a_write(16'h0104, 16'h0000);
      for (int i = 0; i < 4; i++) chars[i] = 8'h00;
      nchar = 0; ndone = 0; nerr = 0; done_c = -1; idle_c = -1;
      busy_ok = 1'b1; hold_ok = 1'b1; stalled = 1'b0; held = 8'h00;
      a_addr = 16'h1002; a_wr = 1'b1; a_wrdata = 16'h0101; a_ready = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk); a_wr = 1'b0; a_ready = (c % 4 == 0); #1;
         if (stalled && !(a_charv === 1'b1 && a_char === held)) hold_ok = 1'b0;
         stalled = (a_charv === 1'b1) && !a_ready;
         held = a_char;
         if (a_charv === 1'b1 && a_ready) begin
            if (nchar < 4) chars[nchar] = a_char;
            nchar++;
         end
         if (ndone == 0 && nerr == 0 && a_wait !== 1'b1) busy_ok = 1'b0;
         if ((ndone + nerr) > 0 && idle_c < 0 && a_wait === 1'b0) idle_c = c;
         if (a_done === 1'b1) begin ndone++; done_c = c; end
         if (a_err === 1'b1) nerr++;
      end
      vec_cnt++;
      if (nchar != 2 || chars[0] !== 8'h48 || chars[1] !== 8'h69)
         begin miss_cnt++; $display("FAIL str_chars got n=%0d %h %h want 2 48 69", nchar, chars[0], chars[1]); end
      vec_cnt++;
      if (ndone != 1 || nerr != 0 || done_c != 10)
         begin miss_cnt++; $display("FAIL str_done got done=%0d err=%0d at %0d want 1 0 at 10", ndone, nerr, done_c); end
      vec_cnt++;
      if (busy_ok !== 1'b1 || idle_c != 11)
         begin miss_cnt++; $display("FAIL str_stall got busy_ok=%b idle_at=%0d want 1 11", busy_ok, idle_c); end
      vec_cnt++;
      if (hold_ok !== 1'b1) begin miss_cnt++; $display("FAIL str_hold got %b want 1", hold_ok); end
   endtask

   task automatic test_max_str();
      logic [7:0] chars [4];
      int ccyc [4];
      int nchar, ndone, nerr, err_c, idle_c;
      a_write(16'hFFFE, 16'h0041);
      a_write(16'h0000, 16'h0042);
      a_write(16'h0002, 16'h0043);
      a_write(16'h0004, 16'h0044);
      a_write(16'h0006, 16'h0045);
      for (int i = 0; i < 4; i++) begin chars[i] = 8'h00; ccyc[i] = -1; end
      nchar = 0; ndone = 0; nerr = 0; err_c = -1; idle_c = -1;
      a_addr = 16'h1002; a_wr = 1'b1; a_wrdata = 16'hFFFE; a_ready = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk); a_wr = 1'b0; #1;
         if (a_charv === 1'b1) begin
            if (nchar < 4) begin chars[nchar] = a_char; ccyc[nchar] = c; end
            nchar++;
         end
         if (nerr > 0 && idle_c < 0 && a_wait === 1'b0) idle_c = c;
         if (a_done === 1'b1) ndone++;
         if (a_err === 1'b1) begin nerr++; err_c = c; end
      end
      vec_cnt++;
      if (nchar != 4 || {chars[0], chars[1], chars[2], chars[3]} !== 32'h41424344)
         begin miss_cnt++; $display("FAIL max_chars got n=%0d %h%h%h%h want 4 41424344", nchar, chars[0], chars[1], chars[2], chars[3]); end
      vec_cnt++;
      if (ccyc[0] != 3 || ccyc[1] != 6 || ccyc[3] != 12)
         begin miss_cnt++; $display("FAIL max_timing got %0d %0d %0d want 3 6 12", ccyc[0], ccyc[1], ccyc[3]); end
      vec_cnt++;
      if (nerr != 1 || ndone != 0 || err_c != 14 || idle_c != 15)
         begin miss_cnt++; $display("FAIL max_err got err=%0d@%0d done=%0d idle@%0d want 1@14 0 idle@15", nerr, err_c, ndone, idle_c); end
   endtask

   task automatic test_reset_mid();
      logic seen;
      int pulses, nchar, ndone, done_c;
      logic [15:0] got;
      a_addr = 16'h1002; a_wr = 1'b1; a_wrdata = 16'h0100; a_ready = 1'b0;
      seen = 1'b0;
      for (int c = 1; c <= 10 && !seen; c++) begin
         @(negedge clk); a_wr = 1'b0; #1;
         if (a_charv === 1'b1) seen = 1'b1;
      end
      vec_cnt++;
      if (seen !== 1'b1) begin miss_cnt++; $display("FAIL mid_emit_timeout got %b want 1", seen); end
      reset = 1'b1;
      pulses = (a_done === 1'b1 || a_err === 1'b1) ? 1 : 0;
      @(negedge clk); reset = 1'b0; #1;
      if (a_done === 1'b1 || a_err === 1'b1) pulses++;
      vec_cnt++;
      if (a_charv !== 1'b0 || a_wait !== 1'b0)
         begin miss_cnt++; $display("FAIL mid_reset got charv=%b wait=%b want 0 0", a_charv, a_wait); end
      @(negedge clk); #1;
      vec_cnt++;
      if (a_charv !== 1'b0 || a_wait !== 1'b0 || pulses != 0)
         begin miss_cnt++; $display("FAIL mid_idle got charv=%b wait=%b pulses=%0d want 0 0 0", a_charv, a_wait, pulses); end
      a_addr = 16'h1002; a_wr = 1'b1; a_wrdata = 16'h0100; a_ready = 1'b1;
      nchar = 0; ndone = 0; done_c = -1; got = 16'h0000;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk); a_wr = 1'b0; #1;
         if (a_charv === 1'b1) begin
            if (nchar < 2) got = {got[7:0], a_char};
            nchar++;
         end
         if (a_done === 1'b1) begin ndone++; done_c = c; end
      end
      vec_cnt++;
      if (nchar != 2 || got !== 16'h4869 || ndone != 1 || done_c != 8)
         begin miss_cnt++; $display("FAIL mid_restart got n=%0d chars=%h done=%0d@%0d want 2 4869 1@8", nchar, got, ndone, done_c); end
   endtask

   initial begin
      reset = 1'b1;
      a_addr = '0; a_rd = 1'b0; a_wr = 1'b0; a_wrdata = '0; a_ready = 1'b0;
      b_addr = '0; b_rd = 1'b0; b_wr = 1'b0; b_wrdata = '0; b_ready = 1'b0;
      test_reset();
      test_read_latency();
      test_back_to_back();
      test_result();
      test_aliasing();
      test_wait_inject();
      test_string();
      test_max_str();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
